// File: rtl/pixel_distributor.sv
`default_nettype none
// ============================================================================
// Module   : pixel_distributor
// Function : Raster-order pixel dispatcher with round-robin engine selection.
//            Optional macro PIXEL_DISTRIBUTOR_STALL_CNT_EN adds stall_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_distributor #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_ENGINES = 4,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   hold,
    input  logic [NUM_ENGINES-1:0] full_queue,
    output logic [NUM_ENGINES-1:0] dispatch,
    output logic [DATA_WIDTH-1:0]  xpixel_o,
    output logic [DATA_WIDTH-1:0]  ypixel_o,
    output logic                   busy,
    output logic                   done
`ifdef PIXEL_DISTRIBUTOR_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);

    localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int X_W   = (IMG_WIDTH   > 1) ? $clog2(IMG_WIDTH)   : 1;
    localparam int Y_W   = (IMG_HEIGHT  > 1) ? $clog2(IMG_HEIGHT)  : 1;

    localparam logic [X_W-1:0] c_X_LAST = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] c_Y_LAST = Y_W'(IMG_HEIGHT - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [X_W-1:0]         r_x;
    logic [Y_W-1:0]         r_y;
    logic [PTR_W-1:0]       r_ptr;
    logic [NUM_ENGINES-1:0] r_dispatch;
    logic [DATA_WIDTH-1:0]  r_xpix;
    logic [DATA_WIDTH-1:0]  r_ypix;
    logic                   w_grant;
    logic [PTR_W-1:0]       w_grant_idx;
    logic [NUM_ENGINES-1:0] w_onehot;
    logic                   w_last;
    logic                   w_load;

    // Engine index arithmetic modulo NUM_ENGINES (need not be a power of two).
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                   input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_ENGINES) begin
            s = s - NUM_ENGINES;
        end
        return PTR_W'(s);
    endfunction

    assign w_last = (r_x == c_X_LAST) && (r_y == c_Y_LAST);
    assign w_load = (r_state == c_IDLE) && start;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_nxt = c_RUN;
            c_RUN:   if (w_grant && w_last) w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // DONE lasts exactly one cycle, the same cycle the final strobe is visible.
    always_comb begin
        busy = (r_state == c_RUN);
        done = (r_state == c_DONE);
    end

    // ------------------------------------------------------------- arbiter
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        if ((r_state == c_RUN) && !hold) begin
            for (int k = 0; k < NUM_ENGINES; k++) begin
                if (!w_grant && !full_queue[wrap_add(r_ptr, k)]) begin
                    w_grant     = 1'b1;
                    w_grant_idx = wrap_add(r_ptr, k);
                end
            end
        end
    end

    always_comb begin
        w_onehot              = '0;
        w_onehot[w_grant_idx] = 1'b1;
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_ptr      <= '0;
            r_dispatch <= '0;
            r_xpix     <= '0;
            r_ypix     <= '0;
        end else begin
            r_dispatch <= '0;
            if (w_load) begin
                r_x   <= '0;
                r_y   <= '0;
                r_ptr <= '0;
            end else if (w_grant) begin
                r_dispatch <= w_onehot;
                r_xpix     <= DATA_WIDTH'(r_x);
                r_ypix     <= DATA_WIDTH'(r_y);
                r_ptr      <= wrap_add(w_grant_idx, 1);
                // Counters park on the last pixel; the next start reloads them.
                if (!w_last) begin
                    if (r_x == c_X_LAST) begin
                        r_x <= '0;
                        r_y <= r_y + Y_W'(1);
                    end else begin
                        r_x <= r_x + X_W'(1);
                    end
                end
            end
        end
    end

    assign dispatch = r_dispatch;
    assign xpixel_o = r_xpix;
    assign ypixel_o = r_ypix;

`ifdef PIXEL_DISTRIBUTOR_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_load) begin
            r_stall_cnt <= '0;
        end else if ((r_state == c_RUN) && !hold && (&full_queue) &&
                     (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    // Stall counter not present in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_distributor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_distributor
// Function : Self-checking bench: vector table, directed scenarios, random run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_distributor;

    localparam int NE = 4;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic [NE-1:0] full_queue = '0;
    logic [NE-1:0] dispatch;
    logic [DW-1:0] xpixel_o;
    logic [DW-1:0] ypixel_o;
    logic          busy;
    logic          done;
`ifdef PIXEL_DISTRIBUTOR_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    pixel_distributor #(
        .DATA_WIDTH (DW),
        .NUM_ENGINES(NE),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .hold      (hold),
        .full_queue(full_queue),
        .dispatch  (dispatch),
        .xpixel_o  (xpixel_o),
        .ypixel_o  (ypixel_o),
        .busy      (busy),
        .done      (done)
`ifdef PIXEL_DISTRIBUTOR_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_disp;
    int n_done;
    int order[$];

    // Reference model: frame as a linear pixel index, phase 0=idle 1=run 2=done.
    int          m_phase;
    int          m_pix;
    int          m_ptr;
    int          m_xo;
    int          m_yo;
    logic [NE-1:0] m_disp;
    logic [31:0] m_stall;

    function automatic void model_reset();
        m_phase = 0; m_pix = 0; m_ptr = 0; m_xo = 0; m_yo = 0;
        m_disp = '0; m_stall = '0;
    endfunction

    function automatic void model_step(bit s, bit h, logic [NE-1:0] f);
        int e;
        e = -1;
        m_disp = '0;
        case (m_phase)
            0: if (s) begin
                m_phase = 1; m_pix = 0; m_ptr = 0; m_stall = '0;
            end
            2: m_phase = 0;
            default: if (!h) begin
                for (int k = 0; k < NE; k++)
                    if (e < 0 && !f[(m_ptr + k) % NE]) e = (m_ptr + k) % NE;
                if (e >= 0) begin
                    m_disp[e] = 1'b1;
                    m_xo  = m_pix % W;
                    m_yo  = m_pix / W;
                    m_ptr = (e + 1) % NE;
                    if (m_pix == W * H - 1) m_phase = 2;
                    else m_pix++;
                end else if (m_stall != 32'hFFFF_FFFF) begin
                    m_stall++;
                end
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input bit s, input bit h, input logic [NE-1:0] f);
        start = s; hold = h; full_queue = f;
        @(posedge clk);
        model_step(s, h, f);
        #1;
        check("model", {dispatch, xpixel_o, ypixel_o, busy, done},
              {m_disp, DW'(m_xo), DW'(m_yo), m_phase == 1, m_phase == 2});
`ifdef PIXEL_DISTRIBUTOR_STALL_CNT_EN
        check("model_stall", 72'(stall_cnt), 72'(m_stall));
`endif
        if (dispatch != '0) begin
            n_disp++;
            for (int e = 0; e < NE; e++) if (dispatch[e]) order.push_back(e);
        end
        if (done) n_done++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        model_reset();
        check("reset_zero", {dispatch, xpixel_o, ypixel_o, busy, done}, '0);
`ifdef PIXEL_DISTRIBUTOR_STALL_CNT_EN
        check("reset_stall", 72'(stall_cnt), '0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic finish_frame();
        repeat (12) tick(0, 0, '0);
    endtask

    typedef struct {
        bit          s;
        bit          h;
        logic [NE-1:0] f;
        logic [NE-1:0] d;
        int          x;
        int          y;
        bit          b;
        bit          dn;
    } vec_t;

    vec_t tbl[10];
    int   exp_skip[8] = '{0, 2, 3, 0, 2, 3, 0, 2};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 4'h0, 4'b0000, 0, 0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 4'h0, 4'b0001, 0, 0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 4'h0, 4'b0010, 1, 0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 4'h0, 4'b0100, 2, 0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 4'h0, 4'b1000, 3, 0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 4'h0, 4'b0001, 0, 1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 4'h0, 4'b0010, 1, 1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 4'h0, 4'b0100, 2, 1, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 4'h0, 4'b1000, 3, 1, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 4'h0, 4'b0000, 3, 1, 1'b0, 1'b0};
        n_disp = 0; n_done = 0;

        model_reset();
        #2;
        check("por_zero", {dispatch, xpixel_o, ypixel_o, busy, done}, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(0, 0, '0);

        // Raster order from the vector table
        for (int i = 0; i < 10; i++) begin
            tick(tbl[i].s, tbl[i].h, tbl[i].f);
            check("raster_vec", {dispatch, xpixel_o, ypixel_o, busy, done},
                  {tbl[i].d, DW'(tbl[i].x), DW'(tbl[i].y), tbl[i].b, tbl[i].dn});
        end

        // Engine 1 permanently full
        order.delete();
        tick(1, 0, 4'b0010);
        repeat (11) tick(0, 0, 4'b0010);
        check("skip_count", 72'(order.size()), 72'(8));
        for (int i = 0; i < 8; i++)
            if (i < order.size()) check("skip_engine", 72'(order[i]), 72'(exp_skip[i]));

        // All queues full for 5 cycles after 3 dispatches
        tick(1, 0, '0);
        repeat (3) tick(0, 0, '0);
        repeat (5) begin
            tick(0, 0, 4'hF);
            check("allfull_nodisp", 72'(dispatch), '0);
        end
`ifdef PIXEL_DISTRIBUTOR_STALL_CNT_EN
        check("allfull_stall", 72'(stall_cnt), 72'(5));
`endif
        tick(0, 0, '0);
        check("allfull_resume", {dispatch, xpixel_o, ypixel_o}, {4'b1000, DW'(3), DW'(0)});
        finish_frame();

        // Hold for 3 cycles at pixel (2,0)
        tick(1, 0, '0);
        repeat (2) tick(0, 0, '0);
        repeat (3) begin
            tick(0, 1, '0);
            check("hold_nodisp", 72'(dispatch), '0);
        end
        tick(0, 0, '0);
        check("hold_resume", {dispatch, xpixel_o, ypixel_o}, {4'b0100, DW'(2), DW'(0)});
        finish_frame();

        // Reset mid-frame
        tick(1, 0, '0);
        repeat (3) tick(0, 0, '0);
        do_reset();
        repeat (3) tick(0, 0, '0);
        check("rst_idle", {dispatch, busy}, '0);
        tick(1, 0, '0);
        tick(0, 0, '0);
        check("rst_newframe", {dispatch, xpixel_o, ypixel_o}, {4'b0001, DW'(0), DW'(0)});
        finish_frame();

        // start pulsed during RUN and while in DONE
        n_disp = 0; n_done = 0;
        tick(1, 0, '0);
        for (int i = 0; i < 12; i++) tick(i == 2 || i == 5 || i == 8, 0, '0);
        check("startign_disp", 72'(n_disp), 72'(8));
        check("startign_done", 72'(n_done), 72'(1));
        check("startign_idle", 72'(busy), '0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            else tick($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                      NE'($urandom & $urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_distributor.md
PIXEL_DISTRIBUTOR -- requirements
Module: pixel_distributor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: coordinate output width.
REQ-002 SHALL have parameter NUM_ENGINES, default 4: number of engines and their queues served.
REQ-003 SHALL have parameter IMG_WIDTH, default 640: pixels per row.
REQ-004 SHALL have parameter IMG_HEIGHT, default 480: rows per frame.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: begin a frame; sampled only in IDLE.
REQ-008 SHALL have port hold, input, 1: freeze dispatch while high.
REQ-009 SHALL have port full_queue, input, NUM_ENGINES: per-engine queue-full flags.
REQ-010 SHALL have port dispatch, output, NUM_ENGINES: one-hot, one-cycle dispatch strobe, wired to each engine's start.
REQ-011 SHALL have port xpixel_o, output, DATA_WIDTH: x coordinate of the dispatched pixel.
REQ-012 SHALL have port ypixel_o, output, DATA_WIDTH: y coordinate of the dispatched pixel.
REQ-013 SHALL have port busy, output, 1: high in RUN.
REQ-014 SHALL have port done, output, 1: one-cycle pulse after the last pixel is dispatched.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE->RUN SHALL occur on start=1; x and y counters SHALL load 0, and the round-robin pointer SHALL load 0.
REQ-017 In RUN, with hold=0, the block SHALL grant the first engine i with full_queue[i]=0, searching from pointer upward modulo NUM_ENGINES.
REQ-018 On a grant, dispatch SHALL be registered: the bit for the granted engine SHALL be high for exactly the next cycle, with xpixel_o/ypixel_o equal to the granted coordinate, zero-extended.
REQ-019 After a grant, pointer SHALL become (granted+1) mod NUM_ENGINES, and the coordinate SHALL advance in raster order: x+1, or x=0 and y+1 when x=IMG_WIDTH-1.
REQ-020 If all full_queue bits are 1, or hold=1, there SHALL be no grant, dispatch SHALL be all zero, and counters and pointer SHALL remain unchanged.
REQ-021 At most one dispatch bit SHALL be high in any cycle, with at most one pixel dispatched per cycle.
REQ-022 A grant of pixel (IMG_WIDTH-1, IMG_HEIGHT-1) SHALL move the FSM to DONE, and done SHALL be 1 for one cycle, coincident with the final dispatch strobe.
REQ-023 DONE->IDLE SHALL occur unconditionally on the next cycle.
REQ-024 start SHALL be ignored in RUN and DONE.
REQ-025 start=1 in the same cycle the FSM enters IDLE from DONE SHALL be ignored, and a new frame SHALL need a start in IDLE.
REQ-026 xpixel_o/ypixel_o SHALL hold their last value when dispatch is zero.
REQ-027 Counter widths SHALL be $clog2 of IMG_WIDTH/IMG_HEIGHT, with no wrap beyond IMG_HEIGHT-1.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, with dispatch=0, xpixel_o=0, ypixel_o=0, busy=0, done=0, counters=0 and pointer=0.
REQ-029 A reset mid-frame SHALL abandon the frame, with no resume, and a new start SHALL be required after reset deasserts.

Configuration
REQ-030 When the macro PIXEL_DISTRIBUTOR_STALL_CNT_EN is defined, the block SHALL add output stall_cnt, 32 bits.
REQ-031 stall_cnt SHALL count RUN cycles in which hold=0 and all full_queue bits are 1, SHALL clear on IDLE->RUN, SHALL saturate at all-ones, and SHALL reset to 0.
REQ-032 When the macro is undefined, the port and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-033 Scenario "raster order": NUM_ENGINES=4, IMG 4x2, full_queue=0, start pulse -> dispatch 0001,0010,0100,1000,0001,... on 8 consecutive cycles, coords (0,0)..(3,0),(0,1)..(3,1), done with the 8th strobe, then busy=0.
REQ-034 Scenario "skip full": full_queue=0010 throughout -> engine 1 never strobed, order 0,2,3,0,2,3,0,2, 8 dispatches total.
REQ-035 Scenario "all full": all four full_queue bits =1 for 5 cycles mid-frame -> no dispatch for 5 cycles, then resume at the same coordinate and pointer; stall_cnt=5 if enabled.
REQ-036 Scenario "hold": hold=1 for 3 cycles at pixel (2,0) -> no dispatch, then (2,0) dispatched first after release.
REQ-037 Scenario "reset mid-frame": reset=0 after 3 dispatches -> all outputs 0 immediately; after release, no dispatch until start; next frame begins at (0,0) to engine 0.
REQ-038 Scenario "start ignored": start pulsed during RUN -> frame continues unchanged, exactly 8 dispatches, single done pulse.
